// File: rtl/hist_eq_ctrl.sv
// hist_eq_ctrl: frame-synchronous controller for the histogram-equalisation
// pipeline. Shadows the contrast parameters and commits them at start-of-frame,
// sequences the pipeline enable (IDLE/WAIT_SOF/CALIB/RUN) and checks geometry.
module hist_eq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = 12
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_aresetn,
  input  logic                  mon_tvalid,
  input  logic                  mon_tuser,
  input  logic                  mon_tlast,
  input  logic                  cfg_enable,
  input  logic                  cfg_update,
  input  logic [DATA_WIDTH-1:0] cfg_contrast_threshold,
  input  logic [9:0]            cfg_upper_bound,
  input  logic [9:0]            cfg_lower_bound,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] contrast_threshold_param,
  output logic [9:0]            upper_bound_param,
  output logic [9:0]            lower_bound_param,
  output logic                  en_module,
  output logic                  update_pending,
  output logic                  mask_valid,
  output logic [15:0]           frame_cnt,
  output logic                  err_cfg,
  output logic                  err_geom
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CALIB    = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam logic [9:0]       UPPER_RST = 10'd717;
  localparam logic [9:0]       LOWER_RST = 10'd205;
  localparam logic [CNT_W-1:0] WIDTH_C   = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] HEIGHT_C  = CNT_W'(IMG_HEIGHT);

  // Counters stick at all-ones so a runaway line cannot wrap back to a legal count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t                  state, state_nxt;
  logic                    frame_inc;
  logic [DATA_WIDTH-1:0]   stg_thr;
  logic [9:0]              stg_upper, stg_lower;
  logic [CNT_W-1:0]        pix_cnt, line_cnt, pix_eff, line_base;
  logic                    geom_bad;

  logic sof, eol, upd_ok, upd_bad, commit_sof, framed;
  assign sof        = mon_tvalid & mon_tuser;
  assign eol        = mon_tvalid & mon_tlast;
  assign upd_ok     = cfg_update & (cfg_lower_bound < cfg_upper_bound);
  assign upd_bad    = cfg_update & ~(cfg_lower_bound < cfg_upper_bound);
  assign commit_sof = update_pending & sof & (state != ST_IDLE);
  assign framed     = (state == ST_CALIB) | (state == ST_RUN);

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next-state logic; disable while framed waits for a frame boundary.
  always_comb begin
    state_nxt = state;
    frame_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_enable) state_nxt = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!cfg_enable) begin
          state_nxt = ST_IDLE;
        end else if (sof) begin
          state_nxt = ST_CALIB;
          frame_inc = 1'b1;
        end
      end
      ST_CALIB, ST_RUN: begin
        if (sof) begin
          if (!cfg_enable) begin
            state_nxt = ST_IDLE;
          end else begin
            frame_inc = 1'b1;
            // New bounds invalidate the statistics of the frame they start.
            if (state == ST_CALIB) state_nxt = ST_RUN;
            else                   state_nxt = commit_sof ? ST_CALIB : ST_RUN;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Geometry: effective counts for this beat and length checks at EOL / SOF.
  always_comb begin
    pix_eff   = sof ? CNT_W'(1) : sat_inc(pix_cnt);
    line_base = sof ? '0 : line_cnt;
    geom_bad  = 1'b0;
    if (eol && (pix_eff != WIDTH_C))                geom_bad = 1'b1;
    if (sof && framed && (line_cnt != HEIGHT_C))    geom_bad = 1'b1;
  end

  // Pixel / line counters advance only on valid beats.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (mon_tvalid) begin
      if (eol) begin
        pix_cnt  <= '0;
        line_cnt <= sat_inc(line_base);
      end else begin
        pix_cnt  <= pix_eff;
        line_cnt <= line_base;
      end
    end
  end

  // Staging and commit of parameters: immediate in IDLE, else at the next SOF.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      contrast_threshold_param <= '0;
      upper_bound_param        <= UPPER_RST;
      lower_bound_param        <= LOWER_RST;
      stg_thr                  <= '0;
      stg_upper                <= UPPER_RST;
      stg_lower                <= LOWER_RST;
      update_pending           <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (upd_ok) begin
        contrast_threshold_param <= cfg_contrast_threshold;
        upper_bound_param        <= cfg_upper_bound;
        lower_bound_param        <= cfg_lower_bound;
        stg_thr                  <= cfg_contrast_threshold;
        stg_upper                <= cfg_upper_bound;
        stg_lower                <= cfg_lower_bound;
        update_pending           <= 1'b0;
      end else if (update_pending) begin
        contrast_threshold_param <= stg_thr;
        upper_bound_param        <= stg_upper;
        lower_bound_param        <= stg_lower;
        update_pending           <= 1'b0;
      end
    end else begin
      if (commit_sof) begin
        contrast_threshold_param <= stg_thr;
        upper_bound_param        <= stg_upper;
        lower_bound_param        <= stg_lower;
      end
      // An update on the SOF beat itself is held for the following SOF.
      if (upd_ok) begin
        stg_thr        <= cfg_contrast_threshold;
        stg_upper      <= cfg_upper_bound;
        stg_lower      <= cfg_lower_bound;
        update_pending <= 1'b1;
      end else if (commit_sof) begin
        update_pending <= 1'b0;
      end
    end
  end

  // Registered status: enable/mask follow the next state, sticky errors favour set.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      en_module  <= 1'b0;
      mask_valid <= 1'b0;
      frame_cnt  <= '0;
      err_cfg    <= 1'b0;
      err_geom   <= 1'b0;
    end else begin
      en_module  <= (state_nxt != ST_IDLE);
      mask_valid <= (state_nxt == ST_RUN);
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      err_cfg    <= (err_cfg  & ~err_clr) | upd_bad;
      err_geom   <= (err_geom & ~err_clr) | geom_bad;
    end
  end

endmodule
